// File: rtl/upsample_pkg.sv
// ==========================================================================
// upsample_pkg: shared mode/state constants and size helper | Rev 1.0
// ==========================================================================
`default_nettype none

package upsample_pkg;

    localparam logic [1:0] MODE_NEAREST = 2'd0;
    localparam logic [1:0] MODE_ZERO    = 2'd1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    // Input plane side for a size code.
    function automatic logic [31:0] side_of(input logic [2:0] code);
        return 32'd4 << code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/upsample_if.sv
// ==========================================================================
// upsample_if: control, input-RAM read port and output stream bundle | Rev 1.0
// ==========================================================================
`default_nettype none

interface upsample_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14,
    parameter int CH_W   = 8
) ();
    logic              start;
    logic [1:0]        mode;
    logic [2:0]        size_code;
    logic [CH_W-1:0]   num_ch_m1;
    logic              busy;
    logic              done;
    logic              err;

    logic              rd_en;
    logic [ADDR_W-1:0] addr_input;
    logic [CH_W-1:0]   in_ch;
    logic [DATA_W-1:0] t_data_in;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] t_data_out;
    logic [ADDR_W-1:0] addr_output;
    logic [CH_W-1:0]   out_ch;

    modport master (
        input  start, mode, size_code, num_ch_m1, t_data_in, out_ready,
        output busy, done, err, rd_en, addr_input, in_ch,
               out_valid, t_data_out, addr_output, out_ch
    );

    modport slave (
        output start, mode, size_code, num_ch_m1, t_data_in, out_ready,
        input  busy, done, err, rd_en, addr_input, in_ch,
               out_valid, t_data_out, addr_output, out_ch
    );
endinterface

`default_nettype wire

// File: rtl/upsample_skid_fifo.sv
// ==========================================================================
// upsample_skid_fifo: 2-entry FIFO with occupancy, push and pop same cycle | Rev 1.0
// ==========================================================================
`default_nettype none

module upsample_skid_fifo #(
    parameter int WIDTH = 39
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && ((r_count != 2'd2) || w_pop);
    assign head   = r_mem[r_rd];
    assign count  = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: rtl/upsample_engine.sv
// ==========================================================================
// upsample_engine: 2x nearest / zero-insert upsampler over C channel planes | Rev 1.0
// ==========================================================================
`default_nettype none

module upsample_engine
    import upsample_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 14,
    parameter int MAX_SIZE_LOG2 = 4,
    parameter int CH_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    upsample_if.master bus
);
    localparam int         CW         = MAX_SIZE_LOG2 + 3;
    localparam int         FW         = DATA_W + ADDR_W + CH_W + 1;
    localparam logic [2:0] C_MAX_CODE = 3'(MAX_SIZE_LOG2);

    logic [2:0]        r_state;
    logic [1:0]        r_mode;
    logic [2:0]        r_size;
    logic [CH_W-1:0]   r_nch;
    logic              r_bad;
    logic [CW-1:0]     r_ox;
    logic [CW-1:0]     r_oy;
    logic [CH_W-1:0]   r_ch;

    logic              r_fl_valid;
    logic [ADDR_W-1:0] r_fl_addr;
    logic [CH_W-1:0]   r_fl_ch;
    logic              r_fl_zero;

    logic [1:0]        w_count;
    logic [FW-1:0]     w_head;
    logic              w_valid;
    logic              w_pop;
    logic              w_rd;
    logic [2:0]        w_occ;
    logic [CW-1:0]     w_last;
    logic              w_last_read;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_out_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [ADDR_W-1:0] w_head_addr;
    logic [CH_W-1:0]   w_head_ch;
    logic              w_head_zero;

    assign w_last      = CW'(2 * side_of(r_size) - 1);
    assign w_last_read = (r_ox == w_last) && (r_oy == w_last) && (r_ch == r_nch);
    assign w_rd_addr   = (ADDR_W'(r_oy >> 1) << (r_size + 3'd2)) | ADDR_W'(r_ox >> 1);
    assign w_out_addr  = (ADDR_W'(r_oy) << (r_size + 3'd3)) | ADDR_W'(r_ox);

    // Credit counts the word leaving this cycle, so a full pipe still issues one read per cycle.
    assign w_valid = (w_count != 2'd0);
    assign w_pop   = w_valid && bus.out_ready;
    assign w_occ   = {1'b0, w_count} + {2'b00, r_fl_valid} - {2'b00, w_pop};
    assign w_rd    = (r_state == ST_RUN) && (w_occ < 3'd2);

    assign bus.rd_en      = w_rd;
    assign bus.addr_input = w_rd_addr;
    assign bus.in_ch      = r_ch;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = (r_state == ST_FIN);
    assign bus.err        = (r_state == ST_FIN) && r_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= 2'd0;
            r_size  <= 3'd0;
            r_nch   <= '0;
            r_bad   <= 1'b0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_ch    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_mode  <= bus.mode;
                        r_size  <= bus.size_code;
                        r_nch   <= bus.num_ch_m1;
                        r_bad   <= 1'b0;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if ((r_size > C_MAX_CODE) || (r_mode > MODE_ZERO)) begin
                        r_bad   <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_ox    <= '0;
                        r_oy    <= '0;
                        r_ch    <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_rd) begin
                        if (r_ox == w_last) begin
                            r_ox <= '0;
                            if (r_oy == w_last) begin
                                r_oy <= '0;
                                r_ch <= r_ch + 1'b1;
                            end else begin
                                r_oy <= r_oy + 1'b1;
                            end
                        end else begin
                            r_ox <= r_ox + 1'b1;
                        end
                        if (w_last_read) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((w_count == 2'd0) && !r_fl_valid) begin
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sideband for the read in flight; joins its RAM word at the capture edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fl_valid <= 1'b0;
            r_fl_addr  <= '0;
            r_fl_ch    <= '0;
            r_fl_zero  <= 1'b0;
        end else begin
            r_fl_valid <= w_rd;
            if (w_rd) begin
                r_fl_addr <= w_out_addr;
                r_fl_ch   <= r_ch;
                r_fl_zero <= (r_mode != MODE_NEAREST) && (r_ox[0] || r_oy[0]);
            end
        end
    end

    upsample_skid_fifo #(
        .WIDTH(FW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (r_fl_valid),
        .push_data({bus.t_data_in, r_fl_addr, r_fl_ch, r_fl_zero}),
        .pop      (w_pop),
        .head     (w_head),
        .count    (w_count)
    );

    assign w_head_data = w_head[FW-1 -: DATA_W];
    assign w_head_addr = w_head[CH_W+1 +: ADDR_W];
    assign w_head_ch   = w_head[1 +: CH_W];
    assign w_head_zero = w_head[0];

    assign bus.out_valid   = w_valid;
    assign bus.t_data_out  = (w_valid && !w_head_zero) ? w_head_data : '0;
    assign bus.addr_output = w_valid ? w_head_addr : '0;
    assign bus.out_ch      = w_valid ? w_head_ch : '0;
endmodule

`default_nettype wire

// File: tb/tb_upsample_engine.sv
// ==========================================================================
// tb_upsample_engine: directed self-checking bench for upsample_engine | Rev 1.0
// ==========================================================================
`default_nettype none

module tb_upsample_engine;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 14;
    localparam int CH_W   = 8;
    localparam int NREC   = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    upsample_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CH_W(CH_W)) bus ();

    upsample_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_SIZE_LOG2(4), .CH_W(CH_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ram_kind = 0;
    logic rand_ready = 1'b0;
    logic fixed_ready = 1'b1;
    logic rnd_bit = 1'b0;
    int unsigned seed_val;

    assign bus.out_ready = rand_ready ? rnd_bit : fixed_ready;

    function automatic logic [15:0] ram_val(input int kind, input int ch, input int addr);
        if (kind == 0) return 16'(100 + 10 * addr);
        return 16'(1000 * ch + addr);
    endfunction

    function automatic logic [15:0] exp_pix(input int m, input int code, input int ch, input int oaddr);
        int s, ts, oy, ox;
        s  = 4 << code;
        ts = 2 * s;
        oy = oaddr / ts;
        ox = oaddr % ts;
        if (m == 1 && ((oy % 2) != 0 || (ox % 2) != 0)) return 16'd0;
        return ram_val(ram_kind, ch, (oy / 2) * s + ox / 2);
    endfunction

    always @(posedge clk) begin
        if (bus.rd_en) bus.t_data_in <= ram_val(ram_kind, int'(bus.in_ch), int'(bus.addr_input));
    end

    always @(posedge clk) begin
        #1;
        rnd_bit <= 1'($urandom_range(1, 0));
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] got_data [NREC];
    logic [13:0] got_addr [NREC];
    logic [7:0]  got_ch   [NREC];
    int          got_cyc  [NREC];
    int acc_count = 0;
    int done_count = 0;
    int rd_count = 0;
    int stall_err = 0;
    logic prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic [13:0] prev_addr = '0;
    logic [7:0]  prev_ch = '0;

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready && acc_count < NREC) begin
            got_data[acc_count] <= bus.t_data_out;
            got_addr[acc_count] <= bus.addr_output;
            got_ch[acc_count]   <= bus.out_ch;
            got_cyc[acc_count]  <= cyc;
            acc_count <= acc_count + 1;
        end
        if (prev_stall && (bus.out_valid !== 1'b1 || bus.t_data_out !== prev_data ||
                           bus.addr_output !== prev_addr || bus.out_ch !== prev_ch))
            stall_err <= stall_err + 1;
        prev_stall <= bus.out_valid && !bus.out_ready;
        prev_data  <= bus.t_data_out;
        prev_addr  <= bus.addr_output;
        prev_ch    <= bus.out_ch;
        if (bus.done) done_count <= done_count + 1;
        if (bus.rd_en) rd_count <= rd_count + 1;
    end

    // Called and returns at 1 ns after a rising edge.
    task automatic start_run(input logic [1:0] m, input logic [2:0] code, input logic [7:0] nch);
        bus.mode      = m;
        bus.size_code = code;
        bus.num_ch_m1 = nch;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit seen);
        cycles = 1;
        while (bus.done !== 1'b1 && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
        seen = (bus.done === 1'b1);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.rd_en !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: got valid=%b rd_en=%b expected 0 0", bus.out_valid, bus.rd_en);
        end
        checks++;
        if ({bus.done, bus.err, bus.t_data_out, bus.addr_output, bus.out_ch, bus.addr_input, bus.in_ch} !== '0) begin
            errors++; $display("FAIL reset_outputs: got data=%0d oaddr=%0d och=%0d iaddr=%0d done=%b err=%b expected all 0",
                               bus.t_data_out, bus.addr_output, bus.out_ch, bus.addr_input, bus.done, bus.err);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_nearest();
        int base, n, cycles;
        bit seen;
        ram_kind = 0; rand_ready = 1'b0; fixed_ready = 1'b1;
        base = acc_count;
        start_run(2'd0, 3'd1, 8'd0);
        wait_done(400, cycles, seen);
        checks++;
        if (!seen || cycles > 261) begin errors++; $display("FAIL nearest_latency: got done=%b after %0d cycles expected done within 261", seen, cycles); end
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL nearest_err: got %b expected 0", bus.err); end
        @(posedge clk); #1;
        n = acc_count - base;
        checks++;
        if (n != 256) begin errors++; $display("FAIL nearest_count: got %0d expected 256", n); end
        checks++;
        if (got_data[base+0] !== 16'd100 || got_data[base+1] !== 16'd100 ||
            got_data[base+16] !== 16'd100 || got_data[base+17] !== 16'd100) begin
            errors++; $display("FAIL nearest_corner: got %0d %0d %0d %0d expected 100 100 100 100",
                               got_data[base+0], got_data[base+1], got_data[base+16], got_data[base+17]);
        end
        checks++;
        if (got_data[base+2] !== 16'd110) begin errors++; $display("FAIL nearest_out2: got %0d expected 110", got_data[base+2]); end
        checks++;
        if (got_data[base+255] !== 16'd730) begin errors++; $display("FAIL nearest_out255: got %0d expected 730", got_data[base+255]); end
        for (int k = 0; k < 256; k++) begin
            checks++;
            if (got_addr[base+k] !== 14'(k) || got_ch[base+k] !== 8'd0 || got_data[base+k] !== exp_pix(0, 1, 0, k)) begin
                errors++; $display("FAIL nearest_word[%0d]: got addr=%0d ch=%0d data=%0d expected addr=%0d ch=0 data=%0d",
                                   k, got_addr[base+k], got_ch[base+k], got_data[base+k], k, exp_pix(0, 1, 0, k));
            end
        end
    endtask

    task automatic test_zero_insert();
        int base, n, cycles;
        bit seen;
        ram_kind = 0; rand_ready = 1'b0; fixed_ready = 1'b1;
        base = acc_count;
        start_run(2'd1, 3'd1, 8'd0);
        wait_done(400, cycles, seen);
        checks++;
        if (!seen || bus.err !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%b err=%b expected 1 0", seen, bus.err); end
        @(posedge clk); #1;
        n = acc_count - base;
        checks++;
        if (n != 256) begin errors++; $display("FAIL zero_count: got %0d expected 256", n); end
        checks++;
        if (got_data[base+0] !== 16'd100 || got_data[base+1] !== 16'd0 ||
            got_data[base+16] !== 16'd0 || got_data[base+17] !== 16'd0) begin
            errors++; $display("FAIL zero_corner: got %0d %0d %0d %0d expected 100 0 0 0",
                               got_data[base+0], got_data[base+1], got_data[base+16], got_data[base+17]);
        end
        checks++;
        if (got_data[base+2] !== 16'd110 || got_data[base+34] !== 16'd190 || got_data[base+255] !== 16'd0) begin
            errors++; $display("FAIL zero_points: got %0d %0d %0d expected 110 190 0",
                               got_data[base+2], got_data[base+34], got_data[base+255]);
        end
        for (int k = 0; k < 256; k++) begin
            checks++;
            if (got_addr[base+k] !== 14'(k) || got_data[base+k] !== exp_pix(1, 1, 0, k)) begin
                errors++; $display("FAIL zero_word[%0d]: got addr=%0d data=%0d expected addr=%0d data=%0d",
                                   k, got_addr[base+k], got_data[base+k], k, exp_pix(1, 1, 0, k));
            end
        end
    endtask

    task automatic test_backpressure();
        int base, n, cycles, st0;
        bit seen;
        ram_kind = 0; rand_ready = 1'b1;
        base = acc_count;
        st0 = stall_err;
        start_run(2'd0, 3'd1, 8'd0);
        wait_done(3000, cycles, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_done: got no done after %0d cycles expected done", cycles); end
        @(posedge clk); #1;
        rand_ready = 1'b0;
        n = acc_count - base;
        checks++;
        if (n != 256) begin errors++; $display("FAIL bp_count: got %0d handshakes expected 256", n); end
        checks++;
        if (stall_err != st0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err - st0); end
        for (int k = 0; k < 256; k++) begin
            checks++;
            if (got_addr[base+k] !== 14'(k) || got_data[base+k] !== exp_pix(0, 1, 0, k)) begin
                errors++; $display("FAIL bp_word[%0d]: got addr=%0d data=%0d expected addr=%0d data=%0d",
                                   k, got_addr[base+k], got_data[base+k], k, exp_pix(0, 1, 0, k));
            end
        end
    endtask

    task automatic test_channels();
        int base, n, cycles, gap, ch, a;
        bit seen;
        ram_kind = 1; rand_ready = 1'b0; fixed_ready = 1'b1;
        base = acc_count;
        start_run(2'd0, 3'd0, 8'd2);
        wait_done(400, cycles, seen);
        checks++;
        if (!seen || cycles > 197) begin errors++; $display("FAIL ch_latency: got done=%b after %0d cycles expected within 197", seen, cycles); end
        @(posedge clk); #1;
        n = acc_count - base;
        checks++;
        if (n != 192) begin errors++; $display("FAIL ch_count: got %0d expected 192", n); end
        gap = got_cyc[base+191] - got_cyc[base];
        checks++;
        if (gap != 191) begin errors++; $display("FAIL ch_no_bubble: got span %0d expected 191", gap); end
        checks++;
        if (got_ch[base+63] !== 8'd0 || got_ch[base+64] !== 8'd1 || got_ch[base+128] !== 8'd2) begin
            errors++; $display("FAIL ch_wrap: got %0d %0d %0d expected 0 1 2", got_ch[base+63], got_ch[base+64], got_ch[base+128]);
        end
        checks++;
        if (got_data[base+191] !== 16'd2015) begin errors++; $display("FAIL ch_plane2_last: got %0d expected 2015", got_data[base+191]); end
        for (int k = 0; k < 192; k++) begin
            ch = k / 64;
            a  = k % 64;
            checks++;
            if (got_ch[base+k] !== 8'(ch) || got_addr[base+k] !== 14'(a) || got_data[base+k] !== exp_pix(0, 0, ch, a)) begin
                errors++; $display("FAIL ch_word[%0d]: got ch=%0d addr=%0d data=%0d expected ch=%0d addr=%0d data=%0d",
                                   k, got_ch[base+k], got_addr[base+k], got_data[base+k], ch, a, exp_pix(0, 0, ch, a));
            end
        end
    endtask

    task automatic test_reset_midrun();
        int base, n, cycles, w;
        bit seen;
        ram_kind = 0; rand_ready = 1'b0; fixed_ready = 1'b1;
        base = acc_count;
        start_run(2'd0, 3'd1, 8'd0);
        w = 0;
        while (acc_count - base < 100 && w < 400) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (acc_count - base < 100) begin errors++; $display("FAIL rst_reach100: got %0d writes expected 100", acc_count - base); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.rd_en !== 1'b0) begin
            errors++; $display("FAIL rst_async_ctrl: got busy=%b valid=%b rd_en=%b expected 0 0 0", bus.busy, bus.out_valid, bus.rd_en);
        end
        checks++;
        if ({bus.done, bus.err, bus.t_data_out, bus.addr_output, bus.out_ch, bus.addr_input, bus.in_ch} !== '0) begin
            errors++; $display("FAIL rst_async_data: got data=%0d oaddr=%0d och=%0d iaddr=%0d ich=%0d expected all 0",
                               bus.t_data_out, bus.addr_output, bus.out_ch, bus.addr_input, bus.in_ch);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        base = acc_count;
        start_run(2'd0, 3'd1, 8'd0);
        wait_done(400, cycles, seen);
        checks++;
        if (!seen || cycles > 261) begin errors++; $display("FAIL rst_rerun_done: got done=%b after %0d cycles expected within 261", seen, cycles); end
        @(posedge clk); #1;
        n = acc_count - base;
        checks++;
        if (n != 256) begin errors++; $display("FAIL rst_rerun_count: got %0d expected 256", n); end
        for (int k = 0; k < 256; k++) begin
            checks++;
            if (got_addr[base+k] !== 14'(k) || got_data[base+k] !== exp_pix(0, 1, 0, k)) begin
                errors++; $display("FAIL rst_rerun_word[%0d]: got addr=%0d data=%0d expected addr=%0d data=%0d",
                                   k, got_addr[base+k], got_data[base+k], k, exp_pix(0, 1, 0, k));
            end
        end
    endtask

    task automatic test_illegal();
        logic [1:0] ms [2];
        logic [2:0] cs [2];
        int cycles, rd0;
        bit seen;
        ms[0] = 2'd0; cs[0] = 3'd5;
        ms[1] = 2'd2; cs[1] = 3'd1;
        for (int i = 0; i < 2; i++) begin
            rd0 = rd_count;
            start_run(ms[i], cs[i], 8'd0);
            wait_done(20, cycles, seen);
            checks++;
            if (!seen || cycles != 2 || bus.err !== 1'b1) begin
                errors++; $display("FAIL illegal_done[%0d]: got done=%b at cycle %0d err=%b expected done at 2 with err=1",
                                   i, seen, cycles, bus.err);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL illegal_pulse[%0d]: got done=%b err=%b busy=%b expected 0 0 0", i, bus.done, bus.err, bus.busy);
            end
            checks++;
            if (rd_count != rd0) begin errors++; $display("FAIL illegal_no_read[%0d]: got %0d reads expected 0", i, rd_count - rd0); end
        end
    endtask

    task automatic test_start_ignored();
        int base, n, cycles, d0;
        bit seen;
        ram_kind = 0; rand_ready = 1'b0; fixed_ready = 1'b1;
        base = acc_count;
        d0 = done_count;
        start_run(2'd0, 3'd0, 8'd0);
        repeat (20) @(posedge clk);
        #1;
        start_run(2'd2, 3'd5, 8'd3);
        wait_done(200, cycles, seen);
        checks++;
        if (!seen || bus.err !== 1'b0) begin errors++; $display("FAIL ign_done: got done=%b err=%b expected 1 0", seen, bus.err); end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (done_count - d0 != 1) begin errors++; $display("FAIL ign_single_done: got %0d done pulses expected 1", done_count - d0); end
        n = acc_count - base;
        checks++;
        if (n != 64) begin errors++; $display("FAIL ign_count: got %0d expected 64", n); end
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (got_addr[base+k] !== 14'(k) || got_data[base+k] !== exp_pix(0, 0, 0, k)) begin
                errors++; $display("FAIL ign_word[%0d]: got addr=%0d data=%0d expected addr=%0d data=%0d",
                                   k, got_addr[base+k], got_data[base+k], k, exp_pix(0, 0, 0, k));
            end
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.mode      = 2'd0;
        bus.size_code = 3'd0;
        bus.num_ch_m1 = 8'd0;
        seed_val = $urandom(32'd12345);
        test_reset();
        test_nearest();
        test_zero_insert();
        test_backpressure();
        test_channels();
        test_reset_midrun();
        test_illegal();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
